// File: rtl/vending_machine_pkg.sv
// Shared types, default parameter values and a slice-extract helper for the
// flattened price/coin-value buses of the vending machine core.
package vending_machine_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_RETURN = 2'd2
   } vm_state_t;

   localparam int VM_DEF_NUM_COINS   = 3;
   localparam int VM_DEF_NUM_ITEMS   = 4;
   localparam int VM_DEF_TOTAL_BITS  = 31;
   localparam int VM_DEF_WAIT_CYCLES = 100;

   // Upper bounds for the generic slice helper; callers zero-extend their bus
   // to VM_MAX_BUS and truncate the result back to their own field width.
   localparam int VM_MAX_BUS  = 2048;
   localparam int VM_MAX_BITS = 64;

   // Returns field idx of a bus made of equal fields of the given width.
   function automatic logic [VM_MAX_BITS-1:0] vm_slice(
      input logic [VM_MAX_BUS-1:0] bus,
      input int                    idx,
      input int                    width
   );
      logic [VM_MAX_BUS-1:0]  shifted;
      logic [VM_MAX_BITS-1:0] mask;
      shifted = bus >> (idx * width);
      mask    = {VM_MAX_BITS{1'b1}} >> (VM_MAX_BITS - width);
      return shifted[VM_MAX_BITS-1:0] & mask;
   endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selection: finds the largest coin that still fits in the
// balance. Coin values are ascending with index, so the highest fitting
// index is the largest coin.
module vm_change_picker
   import vending_machine_pkg::*;
#(
   parameter int NUM_COINS  = VM_DEF_NUM_COINS,
   parameter int TOTAL_BITS = VM_DEF_TOTAL_BITS
) (
   input  logic [TOTAL_BITS-1:0]           balance,
   input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
   output logic [NUM_COINS-1:0]            coin_onehot,
   output logic [TOTAL_BITS-1:0]           coin_amount,
   output logic                            none_fits
);

   logic [TOTAL_BITS-1:0] value [NUM_COINS];

   // Unpack the flattened coin-value bus.
   always_comb begin
      for (int k = 0; k < NUM_COINS; k++) begin
         value[k] = TOTAL_BITS'(vm_slice(VM_MAX_BUS'(coin_value), k, TOTAL_BITS));
      end
   end

   // Scan upward; the last fitting coin seen is the largest one.
   always_comb begin
      coin_onehot = '0;
      coin_amount = '0;
      none_fits   = 1'b1;
      for (int k = 0; k < NUM_COINS; k++) begin
         if (value[k] <= balance) begin
            coin_onehot    = '0;
            coin_onehot[k] = 1'b1;
            coin_amount    = value[k];
            none_fits      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vending_machine_core.sv
// Vending machine core: balance register, inactivity timer, dispense pulses
// and coin-by-coin change return.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | balance is zero, waiting for coins
// S_HOLD   | balance > 0, inactivity timer running
// S_RETURN | ejecting change one coin per cycle
module vending_machine_core
   import vending_machine_pkg::*;
#(
   parameter int NUM_COINS   = VM_DEF_NUM_COINS,
   parameter int NUM_ITEMS   = VM_DEF_NUM_ITEMS,
   parameter int TOTAL_BITS  = VM_DEF_TOTAL_BITS,
   parameter int WAIT_CYCLES = VM_DEF_WAIT_CYCLES
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_COINS-1:0]            i_input_coin,
   input  logic [NUM_ITEMS-1:0]            i_select_item,
   input  logic                            i_trigger_return,
   input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
   input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
   output logic [NUM_ITEMS-1:0]            o_available_item,
   output logic [NUM_ITEMS-1:0]            o_output_item,
   output logic [NUM_COINS-1:0]            o_return_coin,
   output logic [TOTAL_BITS-1:0]           o_current_total,
   output logic                            o_busy
);

   // Wide enough for balance plus the sum of every coin in one cycle.
   localparam int EW = TOTAL_BITS + NUM_COINS + 1;
   localparam int TW = $clog2(WAIT_CYCLES + 1);
   localparam logic [EW-1:0] BAL_MAX = EW'({TOTAL_BITS{1'b1}});

   vm_state_t             state, state_nxt;
   logic [TOTAL_BITS-1:0] balance, balance_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic [NUM_ITEMS-1:0]  output_item_nxt;
   logic [NUM_COINS-1:0]  return_coin_nxt;

   logic [TOTAL_BITS-1:0] price    [NUM_ITEMS];
   logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];

   logic [NUM_ITEMS-1:0]  sel_onehot;
   logic [TOTAL_BITS-1:0] sel_price;
   logic                  sel_valid;
   logic                  grant;
   logic [EW-1:0]         coin_sum;
   logic [TOTAL_BITS-1:0] spend_bal;
   logic [EW-1:0]         total_ext;
   logic                  overflow;
   logic                  reload;
   logic [TOTAL_BITS-1:0] bal_tmp;

   logic [NUM_COINS-1:0]  pick_onehot;
   logic [TOTAL_BITS-1:0] pick_amount;
   logic                  pick_none;

   vm_change_picker #(
      .NUM_COINS  (NUM_COINS),
      .TOTAL_BITS (TOTAL_BITS)
   ) u_picker (
      .balance     (balance),
      .coin_value  (i_coin_value),
      .coin_onehot (pick_onehot),
      .coin_amount (pick_amount),
      .none_fits   (pick_none)
   );

   // Unpack the runtime price and coin-value buses.
   always_comb begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
         price[k] = TOTAL_BITS'(vm_slice(VM_MAX_BUS'(i_item_price), k, TOTAL_BITS));
      end
      for (int k = 0; k < NUM_COINS; k++) begin
         coin_val[k] = TOTAL_BITS'(vm_slice(VM_MAX_BUS'(i_coin_value), k, TOTAL_BITS));
      end
   end

   // Lowest-index requested item wins; granted against the registered balance.
   always_comb begin
      sel_onehot = '0;
      sel_price  = '0;
      sel_valid  = 1'b0;
      for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
         if (i_select_item[k]) begin
            sel_onehot    = '0;
            sel_onehot[k] = 1'b1;
            sel_price     = price[k];
            sel_valid     = 1'b1;
         end
      end
      grant = sel_valid && (sel_price <= balance);
   end

   // Sum of this cycle's coins and the overflow test on the post-spend balance.
   always_comb begin
      coin_sum = '0;
      for (int k = 0; k < NUM_COINS; k++) begin
         if (i_input_coin[k]) begin
            coin_sum = coin_sum + EW'(coin_val[k]);
         end
      end
      spend_bal = grant ? (balance - sel_price) : balance;
      total_ext = EW'(spend_bal) + coin_sum;
      overflow  = total_ext > BAL_MAX;
   end

   // Affordability flags, masked while change is being returned.
   always_comb begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
         o_available_item[k] = (state != S_RETURN) && (price[k] <= balance);
      end
   end

   // Next-state, next-balance, timer and pulse decisions.
   always_comb begin
      state_nxt       = state;
      balance_nxt     = balance;
      timer_nxt       = timer;
      output_item_nxt = '0;
      return_coin_nxt = '0;
      reload          = 1'b0;
      bal_tmp         = balance;
      case (state)
         S_IDLE, S_HOLD: begin
            if ((state == S_HOLD) && i_trigger_return) begin
               state_nxt = S_RETURN;
            end else begin
               bal_tmp = spend_bal;
               if (grant) begin
                  output_item_nxt = sel_onehot;
                  reload          = 1'b1;
               end
               if (|i_input_coin) begin
                  if (!overflow) begin
                     bal_tmp = total_ext[TOTAL_BITS-1:0];
                     reload  = 1'b1;
                  end else begin
                     return_coin_nxt = i_input_coin;
                  end
               end
               balance_nxt = bal_tmp;
               if (reload) begin
                  timer_nxt = TW'(WAIT_CYCLES);
               end else if (state == S_HOLD) begin
                  timer_nxt = timer - TW'(1);
               end
               if (bal_tmp == '0) begin
                  state_nxt = S_IDLE;
               end else if (!reload && (state == S_HOLD) && (timer_nxt == '0)) begin
                  state_nxt = S_RETURN;
               end else begin
                  state_nxt = S_HOLD;
               end
            end
         end
         S_RETURN: begin
            if (pick_none) begin
               balance_nxt = '0;
               state_nxt   = S_IDLE;
            end else begin
               return_coin_nxt = pick_onehot;
               balance_nxt     = balance - pick_amount;
               if (balance == pick_amount) begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt   = S_IDLE;
            balance_nxt = '0;
         end
      endcase
   end

   // State, balance, timer and output pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         balance       <= '0;
         timer         <= '0;
         o_output_item <= '0;
         o_return_coin <= '0;
      end else begin
         state         <= state_nxt;
         balance       <= balance_nxt;
         timer         <= timer_nxt;
         o_output_item <= output_item_nxt;
         o_return_coin <= return_coin_nxt;
      end
   end

   assign o_current_total = balance;
   assign o_busy          = (state == S_RETURN);

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed bench for vending_machine_core: a 31-bit instance (main) and an
// 11-bit instance (overflow), both checked every cycle against a
// transaction-level model plus literal expectations at key points.
module tb_vending_machine_core;

   localparam int NC   = 3;
   localparam int NI   = 4;
   localparam int TBA  = 31;
   localparam int TBB  = 11;
   localparam int WAIT = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int prices [NI] = '{400, 500, 1000, 2000};
   int values [NC] = '{100, 500, 1000};

   logic            a_rst = 1'b0, b_rst = 1'b0;
   logic [NC-1:0]   a_coin = '0, b_coin = '0;
   logic [NI-1:0]   a_sel = '0, b_sel = '0;
   logic            a_trig = 1'b0, b_trig = 1'b0;

   logic [NI*TBA-1:0] price_a;
   logic [NC*TBA-1:0] coinv_a;
   logic [NI*TBB-1:0] price_b;
   logic [NC*TBB-1:0] coinv_b;

   logic [NI-1:0]  a_avail, a_item, b_avail, b_item;
   logic [NC-1:0]  a_ret, b_ret;
   logic [TBA-1:0] a_total;
   logic [TBB-1:0] b_total;
   logic           a_busy, b_busy;

   always_comb begin
      price_a = '0; coinv_a = '0; price_b = '0; coinv_b = '0;
      for (int k = 0; k < NI; k++) begin
         price_a[k*TBA +: TBA] = TBA'(prices[k]);
         price_b[k*TBB +: TBB] = TBB'(prices[k]);
      end
      for (int k = 0; k < NC; k++) begin
         coinv_a[k*TBA +: TBA] = TBA'(values[k]);
         coinv_b[k*TBB +: TBB] = TBB'(values[k]);
      end
   end

   vending_machine_core #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBA), .WAIT_CYCLES(WAIT)) dut_a (
      .clk(clk), .reset_n(a_rst), .i_input_coin(a_coin), .i_select_item(a_sel),
      .i_trigger_return(a_trig), .i_item_price(price_a), .i_coin_value(coinv_a),
      .o_available_item(a_avail), .o_output_item(a_item), .o_return_coin(a_ret),
      .o_current_total(a_total), .o_busy(a_busy));

   vending_machine_core #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBB), .WAIT_CYCLES(WAIT)) dut_b (
      .clk(clk), .reset_n(b_rst), .i_input_coin(b_coin), .i_select_item(b_sel),
      .i_trigger_return(b_trig), .i_item_price(price_b), .i_coin_value(coinv_b),
      .o_available_item(b_avail), .o_output_item(b_item), .o_return_coin(b_ret),
      .o_current_total(b_total), .o_busy(b_busy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: mode 0 = no money, 1 = holding money, 2 = paying out change.
   typedef struct {
      longint        bal;
      int            mode;
      int            idle;
      logic [NI-1:0] item;
      logic [NC-1:0] ret;
   } model_t;

   model_t ma, mb;

   task automatic model_step(inout model_t m, input longint maxv, input logic rst,
                             input logic [NC-1:0] coins, input logic [NI-1:0] sel,
                             input logic trig);
      longint b, sum;
      int     best;
      bit     active;
      m.item = '0;
      m.ret  = '0;
      if (!rst) begin
         m.bal = 0; m.mode = 0; m.idle = 0;
      end else if (m.mode == 2) begin
         best = -1;
         for (int k = 0; k < NC; k++) if (values[k] <= m.bal) best = k;
         if (best < 0) begin
            m.bal = 0; m.mode = 0;
         end else begin
            m.ret[best] = 1'b1;
            m.bal -= values[best];
            if (m.bal == 0) m.mode = 0;
         end
      end else if (m.mode == 1 && trig) begin
         m.mode = 2;
      end else begin
         active = 0;
         b = m.bal;
         for (int k = 0; k < NI; k++) begin
            if (sel[k]) begin
               if (prices[k] <= b) begin
                  b -= prices[k]; m.item[k] = 1'b1; active = 1;
               end
               break;
            end
         end
         if (coins != '0) begin
            sum = 0;
            for (int k = 0; k < NC; k++) if (coins[k]) sum += values[k];
            if (b + sum <= maxv) begin
               b += sum; active = 1;
            end else begin
               m.ret = coins;
            end
         end
         m.bal = b;
         if (active) m.idle = 0;
         else if (m.mode == 1) m.idle++;
         if (b == 0) m.mode = 0;
         else if (m.mode == 1 && !active && m.idle >= WAIT) m.mode = 2;
         else m.mode = 1;
      end
   endtask

   function automatic logic [NI-1:0] model_avail(input model_t m);
      logic [NI-1:0] r;
      r = '0;
      for (int k = 0; k < NI; k++) r[k] = (m.mode != 2) && (prices[k] <= m.bal);
      return r;
   endfunction

   // Advance both models at each edge and compare every output just after it.
   always @(posedge clk) begin
      model_step(ma, 64'h7FFF_FFFF, a_rst, a_coin, a_sel, a_trig);
      model_step(mb, 64'h7FF,       b_rst, b_coin, b_sel, b_trig);
      #1;
      chk("cyc_a_total", a_total, ma.bal);
      chk("cyc_a_item",  a_item,  ma.item);
      chk("cyc_a_ret",   a_ret,   ma.ret);
      chk("cyc_a_busy",  a_busy,  ma.mode == 2);
      chk("cyc_a_avail", a_avail, model_avail(ma));
      chk("cyc_b_total", b_total, mb.bal);
      chk("cyc_b_ret",   b_ret,   mb.ret);
      chk("cyc_b_busy",  b_busy,  mb.mode == 2);
      chk("cyc_b_avail", b_avail, model_avail(mb));
   end

   // One clock with the given inputs on instance A; returns at the next negedge.
   task automatic cyc_a(input logic [NC-1:0] c, input logic [NI-1:0] s, input logic t);
      a_coin = c; a_sel = s; a_trig = t;
      @(negedge clk);
      a_coin = '0; a_sel = '0; a_trig = 1'b0;
   endtask

   task automatic cyc_b(input logic [NC-1:0] c, input logic t);
      b_coin = c; b_trig = t;
      @(negedge clk);
      b_coin = '0; b_trig = 1'b0;
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) cyc_a('0, '0, 1'b0);
   endtask

   initial begin
      ma = '{bal: 0, mode: 0, idle: 0, item: '0, ret: '0};
      mb = ma;
      @(negedge clk);
      @(negedge clk);
      chk("rst_total", a_total, 0);
      chk("rst_item",  a_item, 0);
      chk("rst_ret",   a_ret, 0);
      chk("rst_busy",  a_busy, 0);
      a_rst = 1'b1; b_rst = 1'b1;

      // First coin and a dispense.
      cyc_a(3'b010, 4'b0000, 1'b0);
      chk("coin500_total", a_total, 500);
      chk("coin500_avail", a_avail, 4'b0011);
      cyc_a(3'b000, 4'b0001, 1'b0);
      chk("sel0_item",  a_item, 4'b0001);
      chk("sel0_total", a_total, 100);
      idle_a(1);
      chk("sel0_pulse_once", a_item, 4'b0000);

      // Balance 300: same-cycle select (refused) plus coin.
      cyc_a(3'b001, 4'b0000, 1'b0);
      cyc_a(3'b001, 4'b0000, 1'b0);
      cyc_a(3'b001, 4'b0001, 1'b0);
      chk("refuse_item",  a_item, 4'b0000);
      chk("refuse_total", a_total, 400);

      // Balance 1600 then let the inactivity timer expire.
      cyc_a(3'b100, 4'b0000, 1'b0);
      cyc_a(3'b001, 4'b0000, 1'b0);
      cyc_a(3'b001, 4'b0000, 1'b0);
      chk("pre_timeout_total", a_total, 1600);
      idle_a(WAIT - 1);
      chk("timer_not_yet", a_busy, 0);
      idle_a(1);
      chk("timer_expired", a_busy, 1);
      idle_a(1);
      chk("ret1_coin",  a_ret, 3'b100);
      chk("ret1_total", a_total, 600);
      idle_a(1);
      chk("ret2_coin",  a_ret, 3'b010);
      idle_a(1);
      chk("ret3_coin",  a_ret, 3'b001);
      chk("ret3_total", a_total, 0);
      chk("ret3_busy",  a_busy, 0);

      // Trigger return; coins ignored while returning; reset mid-return.
      cyc_a(3'b111, 4'b0000, 1'b0);
      chk("multi_coin_total", a_total, 1600);
      cyc_a(3'b000, 4'b0001, 1'b1);
      chk("trig_busy",  a_busy, 1);
      chk("trig_item",  a_item, 4'b0000);
      chk("trig_avail", a_avail, 4'b0000);
      cyc_a(3'b100, 4'b0000, 1'b0);
      chk("ret_coin_ignored", a_total, 600);
      cyc_a(3'b000, 4'b0000, 1'b0);
      chk("second_pulse", a_ret, 3'b010);
      a_rst = 1'b0;
      idle_a(1);
      a_rst = 1'b1;
      chk("midrst_ret",   a_ret, 0);
      chk("midrst_total", a_total, 0);
      chk("midrst_busy",  a_busy, 0);

      // Trigger in idle has no effect.
      cyc_a(3'b000, 4'b0000, 1'b1);
      chk("idle_trig_busy", a_busy, 0);

      // Lowest-index select wins, then exact spend back to idle.
      cyc_a(3'b100, 4'b0000, 1'b0);
      cyc_a(3'b100, 4'b0000, 1'b0);
      cyc_a(3'b000, 4'b1110, 1'b0);
      chk("prio_item",  a_item, 4'b0010);
      chk("prio_total", a_total, 1500);
      cyc_a(3'b000, 4'b0100, 1'b0);
      cyc_a(3'b000, 4'b0010, 1'b0);
      chk("exact_total", a_total, 0);
      chk("exact_avail", a_avail, 4'b0000);

      // Runtime price change leaves a residue below the smallest coin.
      cyc_a(3'b010, 4'b0000, 1'b0);
      prices[0] = 450;
      cyc_a(3'b000, 4'b0001, 1'b0);
      chk("residue_total", a_total, 50);
      cyc_a(3'b000, 4'b0000, 1'b1);
      idle_a(1);
      chk("residue_ret",   a_ret, 0);
      chk("residue_total0", a_total, 0);
      chk("residue_busy",  a_busy, 0);
      prices[0] = 400;
      idle_a(1);

      // 11-bit instance: a coin that would overflow is echoed back.
      cyc_b(3'b100, 1'b0);
      cyc_b(3'b100, 1'b0);
      cyc_b(3'b001, 1'b0);
      chk("ovf_ret",   b_ret, 3'b001);
      chk("ovf_total", b_total, 2000);
      cyc_b(3'b000, 1'b1);
      chk("ovf_echo_once", b_ret, 3'b000);
      cyc_b(3'b000, 1'b0);
      chk("b_ret1", b_ret, 3'b100);
      cyc_b(3'b000, 1'b0);
      cyc_b(3'b000, 1'b0);
      chk("b_done_total", b_total, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
